beep_gen: RTL and testbench
===========================

BEEP_GEN -- requirements
Module: beep_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the i_clk frequency in Hz.
REQ-002 SHALL have parameter EAT_MS, default 100, meaning the eat-beep duration in ms.
REQ-003 SHALL have parameter NOTE_MS, default 200, meaning the duration of each game-over note in ms.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port i_eat, input, 1 bit: one-cycle pulse when food is eaten.
REQ-007 SHALL have port i_gameOver, input, 1 bit: level, high while the game is over.
REQ-008 SHALL have port o_speaker, output, 1 bit: square-wave drive to the piezo.
REQ-009 SHALL have port o_active, output, 1 bit: high while any tone is playing; feeds the status-LED block's speaker input.

Function
REQ-010 SHALL implement states IDLE, EAT, GO1, GO2, GO3.
REQ-011 SHALL tone a state by toggling o_speaker every HALF cycles, where HALF = CLK_HZ/(2*f) truncated: EAT f=1000 Hz, GO1 880 Hz, GO2 660 Hz, GO3 440 Hz.
REQ-012 SHALL set state length LEN = CLK_HZ/1000*ms cycles, with ms = EAT_MS for EAT and NOTE_MS for GO1-GO3.
REQ-013 SHALL detect a game-over rising edge (i_gameOver=1 with its registered previous value 0) sampled at edge N and enter GO1 at edge N+1 from any state.
REQ-014 SHALL take an i_eat sampled high at edge N in IDLE or EAT with no game-over rising edge, then enter or restart EAT at N+1 (retrigger restarts the duration and the tone phase).
REQ-015 SHALL ignore i_eat while in GO1-GO3, and give a game-over rising edge priority over a simultaneous i_eat.
REQ-016 SHALL transition GO1->GO2->GO3->IDLE and EAT->IDLE after exactly LEN cycles in the state; GO1-GO3 have no gap between them.
REQ-017 SHALL start every state entry with o_speaker=0 and the half-period and duration counters cleared; the first toggle occurs HALF cycles after entry.
REQ-018 SHALL make o_active a registered output, 1 in EAT/GO1/GO2/GO3 and 0 in IDLE, so it is high exactly on the cycles the state is non-IDLE.
REQ-019 SHALL force o_speaker=0 in IDLE.
REQ-020 SHALL not retrigger while i_gameOver stays high; only a fresh 0->1 restarts GO1.
REQ-021 SHALL size counters to $clog2 of the largest LEN/HALF, with no wrap inside a state.

Reset
REQ-022 SHALL, with i_rst_n=0 at a rising edge, set the state to IDLE, o_speaker=0, o_active=0, the counters to 0, and the edge-detect register to 0 on the next cycle.
REQ-023 SHALL abort any tone when reset is asserted mid-tone, with no residual toggle after reset.
REQ-024 SHALL treat i_gameOver already high when reset releases as a rising edge, which plays the game-over sequence.

Configuration
REQ-025 SHALL, with BEEP_MUTE_EN defined, add port i_mute (input, 1 bit); while i_mute=1, o_speaker is forced to 0 while the state machine, counters and o_active behave unchanged.
REQ-026 SHALL, with BEEP_MUTE_EN undefined, have no i_mute port and leave o_speaker never masked.

Structure
REQ-027 SHALL place the state enum, tone frequencies (1000/880/660/440) and HALF/LEN helper functions in package snake_sound_pkg.
REQ-028 SHALL use one sub-module, tone_osc: a half-period counter with a synchronous clear that outputs the square wave; beep_gen holds the FSM and duration counter.

Verification (CLK_HZ=20_000, EAT_MS=100, NOTE_MS=200: EAT HALF=10/LEN=2000, GO HALF=11/15/22, LEN=4000)
REQ-029 SHALL cover: i_eat pulse at cycle 0 -> o_active=1 for cycles 1..2000, o_speaker toggles at cycles 11, 21, ... (200 toggles), then 0.
REQ-030 SHALL cover: i_eat again at cycle 1000 of EAT -> EAT restarts, o_active stays high until cycle 3001.
REQ-031 SHALL cover: i_gameOver rises during EAT -> GO1 the next cycle; o_active high for 12000 cycles; measured half-periods 11, 15, 22; i_eat pulses inside are ignored.
REQ-032 SHALL cover: i_gameOver and i_eat rise together -> GO1 entered, never EAT.
REQ-033 SHALL cover: i_rst_n=0 at cycle 500 of GO2 -> next cycle o_speaker=0, o_active=0; with i_gameOver held high, releasing reset gives GO1.
REQ-034 SHALL cover, with BEEP_MUTE_EN and i_mute=1 during an EAT: o_speaker stays 0, while o_active timing is identical to REQ-029.

Source files
------------

// File: rtl/snake_sound_pkg.sv
// Shared definitions for the snake-game sound block: state encoding,
// tone frequencies and cycle-count helpers used to size the counters.
package snake_sound_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EAT  = 3'd1,
    ST_GO1  = 3'd2,
    ST_GO2  = 3'd3,
    ST_GO3  = 3'd4
  } beep_state_e;

  localparam int unsigned F_EAT_HZ = 1000;
  localparam int unsigned F_GO1_HZ = 880;
  localparam int unsigned F_GO2_HZ = 660;
  localparam int unsigned F_GO3_HZ = 440;

  // Clocks per half period of a tone, truncated.
  function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                              input int unsigned f_hz);
    return clk_hz / (2 * f_hz);
  endfunction

  // Clocks spent in a state lasting ms milliseconds.
  function automatic int unsigned len_cycles(input int unsigned clk_hz,
                                             input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int unsigned max2(input int unsigned a,
                                       input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave oscillator: toggles o_wave every (i_half_m1 + 1) clocks.
// i_clr restarts the phase (counter and output both zero).
module tone_osc #(
  parameter int unsigned HALF_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic [HALF_W-1:0] i_half_m1,
  output logic              o_wave
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              wave_q, wave_d;

  // Half-period count and toggle; clear has priority.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    wave_d = wave_q;
    if (i_clr) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (cnt_q == i_half_m1) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end
  end

  // Oscillator registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign o_wave = wave_q;

endmodule

// File: rtl/beep_gen.sv
// Piezo sound generator: short beep on food eaten, three-note falling
// sequence on game over. Define BEEP_MUTE_EN to add an i_mute input that
// silences o_speaker without changing sequencing or o_active.
module beep_gen
  import snake_sound_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned EAT_MS  = 100,
  parameter int unsigned NOTE_MS = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_eat,
  input  logic i_gameOver,
`ifdef BEEP_MUTE_EN
  input  logic i_mute,
`endif
  output logic o_speaker,
  output logic o_active
);

  localparam int unsigned EAT_HALF = half_cycles(CLK_HZ, F_EAT_HZ);
  localparam int unsigned GO1_HALF = half_cycles(CLK_HZ, F_GO1_HZ);
  localparam int unsigned GO2_HALF = half_cycles(CLK_HZ, F_GO2_HZ);
  localparam int unsigned GO3_HALF = half_cycles(CLK_HZ, F_GO3_HZ);
  localparam int unsigned EAT_LEN  = len_cycles(CLK_HZ, EAT_MS);
  localparam int unsigned NOTE_LEN = len_cycles(CLK_HZ, NOTE_MS);

  localparam int unsigned MAX_HALF = max2(max2(EAT_HALF, GO1_HALF),
                                          max2(GO2_HALF, GO3_HALF));
  localparam int unsigned MAX_LEN  = max2(EAT_LEN, NOTE_LEN);
  localparam int unsigned HALF_W   = cnt_width(MAX_HALF);
  localparam int unsigned DUR_W    = cnt_width(MAX_LEN);

  localparam logic [HALF_W-1:0] EAT_HM1   = HALF_W'(EAT_HALF - 1);
  localparam logic [HALF_W-1:0] GO1_HM1   = HALF_W'(GO1_HALF - 1);
  localparam logic [HALF_W-1:0] GO2_HM1   = HALF_W'(GO2_HALF - 1);
  localparam logic [HALF_W-1:0] GO3_HM1   = HALF_W'(GO3_HALF - 1);
  localparam logic [DUR_W-1:0]  EAT_LAST  = DUR_W'(EAT_LEN - 1);
  localparam logic [DUR_W-1:0]  NOTE_LAST = DUR_W'(NOTE_LEN - 1);

  beep_state_e       state_q, state_d, next_after;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              active_q, active_d;
  logic              go_prev_q, go_prev_d;
  logic              go_rise, dur_last, enter_st, osc_clr;
  logic [HALF_W-1:0] half_m1;
  logic              wave;

  assign go_rise = i_gameOver & ~go_prev_q;

  // Next state, duration count and tone selection. A game-over edge beats
  // everything; an eat pulse only matters outside the game-over notes.
  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q + 1'b1;
    enter_st   = 1'b0;
    dur_last   = 1'b0;
    next_after = ST_IDLE;
    half_m1    = '0;
    case (state_q)
      ST_IDLE: begin
        dur_last = 1'b0;
      end
      ST_EAT: begin
        dur_last = (dur_q == EAT_LAST);
        half_m1  = EAT_HM1;
      end
      ST_GO1: begin
        dur_last   = (dur_q == NOTE_LAST);
        next_after = ST_GO2;
        half_m1    = GO1_HM1;
      end
      ST_GO2: begin
        dur_last   = (dur_q == NOTE_LAST);
        next_after = ST_GO3;
        half_m1    = GO2_HM1;
      end
      ST_GO3: begin
        dur_last = (dur_q == NOTE_LAST);
        half_m1  = GO3_HM1;
      end
      default: begin
        dur_last = 1'b1;
      end
    endcase

    if (go_rise) begin
      state_d  = ST_GO1;
      enter_st = 1'b1;
    end else if (i_eat && (state_q == ST_IDLE || state_q == ST_EAT)) begin
      state_d  = ST_EAT;
      enter_st = 1'b1;
    end else if (dur_last) begin
      state_d  = next_after;
      enter_st = 1'b1;
    end

    if (enter_st || state_d == ST_IDLE) begin
      dur_d = '0;
    end

    active_d  = (state_d != ST_IDLE);
    go_prev_d = i_gameOver;
    osc_clr   = enter_st || (state_d == ST_IDLE);
  end

  // FSM, duration counter, registered o_active and game-over edge register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      dur_q     <= '0;
      active_q  <= 1'b0;
      go_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      active_q  <= active_d;
      go_prev_q <= go_prev_d;
    end
  end

  tone_osc #(
    .HALF_W (HALF_W)
  ) u_osc (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (osc_clr),
    .i_half_m1 (half_m1),
    .o_wave    (wave)
  );

`ifdef BEEP_MUTE_EN
  assign o_speaker = wave & ~i_mute;
`else
  assign o_speaker = wave;
`endif

  assign o_active = active_q;

endmodule

// File: tb/tb_beep_gen.sv
// Bench for beep_gen at CLK_HZ=20_000: EAT half 10 / length 2000,
// game-over halves 11/15/22 with 4000-cycle notes. Expected speaker toggle
// cycles and o_active edge cycles are queued when stimulus is planned and
// popped as the monitor sees each output change.
module tb_beep_gen;

  localparam int CLK_HZ   = 20_000;
  localparam int EAT_HALF = 10;
  localparam int EAT_LEN  = 2000;
  localparam int NOTE_LEN = 4000;
  localparam int GO1_HALF = 11;
  localparam int GO2_HALF = 15;
  localparam int GO3_HALF = 22;

  logic clk = 1'b0;
  logic rst_n, eat, go;
  logic o_speaker, o_active;
`ifdef BEEP_MUTE_EN
  logic mute;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_spk_q[$];
  logic [31:0] exp_act_q[$];

  logic mon_en = 1'b0;
  logic spk_prev, act_prev;

  beep_gen #(
    .CLK_HZ  (CLK_HZ),
    .EAT_MS  (100),
    .NOTE_MS (200)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_eat      (eat),
    .i_gameOver (go),
`ifdef BEEP_MUTE_EN
    .i_mute     (mute),
`endif
    .o_speaker  (o_speaker),
    .o_active   (o_active)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: every output change is matched against the next expected cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_speaker !== spk_prev) begin
        if (exp_spk_q.size() == 0) chk("spk_extra_toggle", cyc, 32'hFFFF_FFFF);
        else chk("spk_toggle_cycle", cyc, exp_spk_q.pop_front());
      end
      if (o_active !== act_prev) begin
        if (exp_act_q.size() == 0) chk("act_extra_edge", cyc, 32'hFFFF_FFFF);
        else chk("act_edge_cycle", cyc, exp_act_q.pop_front());
      end
    end
    spk_prev = o_speaker;
    act_prev = o_active;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_eat();
    eat = 1'b1;
    tick();
    eat = 1'b0;
  endtask

  // Toggles of a tone entered at 'entry' that runs 'seg' cycles; an odd
  // count leaves the speaker high, so the exit forces one more change.
  task automatic push_seg(input int entry, input int half, input int seg);
    int n = 0;
    for (int t = entry + half; t < entry + seg; t += half) begin
      exp_spk_q.push_back(t);
      n++;
    end
    if (n % 2 == 1) exp_spk_q.push_back(entry + seg);
  endtask

  task automatic push_go(input int entry);
    push_seg(entry, GO1_HALF, NOTE_LEN);
    push_seg(entry + NOTE_LEN, GO2_HALF, NOTE_LEN);
    push_seg(entry + 2 * NOTE_LEN, GO3_HALF, NOTE_LEN);
  endtask

  // Eat beep retriggered 'off' cycles after entry (off in 0..EAT_LEN-1).
  task automatic eat_retrig(input int off);
    int t, e, r, e2;
    t  = cyc;
    e  = t + 1;
    r  = e + off;
    e2 = r + 1;
    exp_act_q.push_back(e);
    exp_act_q.push_back(e2 + EAT_LEN);
    push_seg(e, EAT_HALF, e2 - e);
    push_seg(e2, EAT_HALF, EAT_LEN);
    pulse_eat();
    wait_until(r);
    pulse_eat();
    wait_until(e2 + EAT_LEN + 20);
  endtask

  initial begin
    int t, e, g, s, go2, c, s2;
    rst_n = 1'b0;
    eat   = 1'b0;
    go    = 1'b0;
`ifdef BEEP_MUTE_EN
    mute  = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_active", o_active, 0);
    chk("reset_speaker", o_speaker, 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (5) tick();

    // Single eat beep
    t = cyc;
    e = t + 1;
    exp_act_q.push_back(e);
    exp_act_q.push_back(e + EAT_LEN);
    push_seg(e, EAT_HALF, EAT_LEN);
    pulse_eat();
    wait_until(e + EAT_LEN + 50);

    // Retrigger at cycle 1000 of the beep, then on its last cycle, then random
    eat_retrig(999);
    eat_retrig(EAT_LEN - 1);
    repeat (2) eat_retrig($urandom_range(0, EAT_LEN - 1));

    // Game over during an eat beep; eat pulses inside the notes are ignored
    t = cyc;
    e = t + 1;
    g = e + 300;
    exp_act_q.push_back(e);
    exp_act_q.push_back(g + 1 + 3 * NOTE_LEN);
    push_seg(e, EAT_HALF, g + 1 - e);
    push_go(g + 1);
    pulse_eat();
    wait_until(g);
    go = 1'b1;
    wait_until(g + 2000);
    pulse_eat();
    wait_until(g + 6000);
    pulse_eat();
    wait_until(g + 1 + 3 * NOTE_LEN + 100);
    chk("go_held_no_retrigger", o_active, 0);
    go = 1'b0;
    repeat (5) tick();

    // Game over and eat in the same cycle
    t = cyc;
    exp_act_q.push_back(t + 1);
    exp_act_q.push_back(t + 1 + 3 * NOTE_LEN);
    push_go(t + 1);
    eat = 1'b1;
    go  = 1'b1;
    tick();
    eat = 1'b0;
    wait_until(t + 1 + 3 * NOTE_LEN + 100);
    go = 1'b0;
    repeat (5) tick();

    // Reset at cycle 500 of GO2 with game over held, then replay from GO1
    t   = cyc;
    s   = t + 1;
    go2 = s + NOTE_LEN;
    c   = go2 + 499;
    s2  = c + 2;
    exp_act_q.push_back(s);
    exp_act_q.push_back(c + 1);
    push_seg(s, GO1_HALF, NOTE_LEN);
    push_seg(go2, GO2_HALF, c + 1 - go2);
    exp_act_q.push_back(s2);
    exp_act_q.push_back(s2 + 3 * NOTE_LEN);
    push_go(s2);
    go = 1'b1;
    wait_until(c);
    rst_n = 1'b0;
    tick();
    chk("midtone_reset_active", o_active, 0);
    chk("midtone_reset_speaker", o_speaker, 0);
    rst_n = 1'b1;
    wait_until(s2 + 3 * NOTE_LEN + 100);
    go = 1'b0;
    repeat (5) tick();

`ifdef BEEP_MUTE_EN
    // Muted eat beep: o_active timing unchanged, no speaker activity
    mute = 1'b1;
    t = cyc;
    exp_act_q.push_back(t + 1);
    exp_act_q.push_back(t + 1 + EAT_LEN);
    pulse_eat();
    wait_until(t + 1 + EAT_LEN + 50);
    mute = 1'b0;
`endif

    // Final report
    chk("spk_expect_left", exp_spk_q.size(), 0);
    chk("act_expect_left", exp_act_q.size(), 0);
    chk("end_active", o_active, 0);
    chk("end_speaker", o_speaker, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
